// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the PC into a combinational instruction memory,
// buffers fetched {word, pc} pairs in a small FIFO and hands them to decode
// over valid/ready. A redirect flushes the FIFO and reloads the PC.
module fetch_sequencer #(
  parameter int             n        = 32,
  parameter int             r        = 6,
  parameter int             QDEPTH   = 2,
  parameter logic [r-1:0]   RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  output logic [r-1:0]   imemAddr,
  input  logic [n-1:0]   imemData,
  output logic [n-1:0]   instr,
  output logic [r-1:0]   instrPC,
  output logic           instrValid,
  input  logic           instrReady,
  input  logic           redirect,
  input  logic [r-1:0]   redirectPC,
  output logic [15:0]    fetchCount
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(QDEPTH);

  logic [r-1:0]  pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [15:0]   fetch_count_q, fetch_count_d;
  logic [n-1:0]  data_q [QDEPTH];
  logic [n-1:0]  data_d [QDEPTH];
  logic [r-1:0]  pcbuf_q [QDEPTH];
  logic [r-1:0]  pcbuf_d [QDEPTH];

  logic instr_valid;
  logic pop;
  logic push;

  // Handshake qualifiers: a full buffer can still accept a word when the head leaves.
  always_comb begin
    instr_valid = (count_q != '0);
    pop         = instr_valid & instrReady;
    push        = enable & ~redirect & ((count_q < CNT_FULL) | pop);
  end

  // Next-state for PC, FIFO pointers/storage and the accept counter.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    data_d        = data_q;
    pcbuf_d       = pcbuf_q;
    fetch_count_d = fetch_count_q;

    // The head accepted in a redirect cycle still counts as delivered.
    if (pop && fetch_count_q != 16'hFFFF) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    if (redirect) begin
      pc_d    = redirectPC;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (push) begin
        data_d[tail_q]  = imemData;
        pcbuf_d[tail_q] = pc_q;
        tail_d          = tail_q + PW'(1);
        pc_d            = pc_q + r'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State registers; reset discards any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fetch_count_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        data_q[i]  <= '0;
        pcbuf_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fetch_count_q <= fetch_count_d;
      data_q        <= data_d;
      pcbuf_q       <= pcbuf_d;
    end
  end

  // Outputs: head fields are forced to zero whenever nothing is valid.
  always_comb begin
    imemAddr   = pc_q;
    instrValid = instr_valid;
    instr      = instr_valid ? data_q[head_q]  : '0;
    instrPC    = instr_valid ? pcbuf_q[head_q] : '0;
    fetchCount = fetch_count_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 64-word combinational memory model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [5:0]  imemAddr;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [5:0]  instrPC;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [5:0]  redirectPC;
  logic [15:0] fetchCount;

  logic [31:0] imem [64];
  int checks;
  int errors;

  fetch_sequencer #(.n(32), .r(6), .QDEPTH(2), .RESET_PC(6'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .imemAddr   (imemAddr),
    .imemData   (imemData),
    .instr      (instr),
    .instrPC    (instrPC),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .fetchCount (fetchCount)
  );

  assign imemData = imem[imemAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    instrReady = 1'b0;
    redirect   = 1'b0;
    redirectPC = 6'd0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 + i;

    // Reset state
    do_reset();
    check("rst_addr",  {26'd0, imemAddr}, 32'd0);
    check("rst_valid", {31'd0, instrValid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc",    {26'd0, instrPC}, 32'd0);
    check("rst_cnt",   {16'd0, fetchCount}, 32'd0);

    // 1: streaming, one instruction per cycle
    enable = 1'b1; instrReady = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("s1_valid%0d", i), {31'd0, instrValid}, 32'd1);
      check($sformatf("s1_instr%0d", i), instr, 32'h1000_0000 + i);
      check($sformatf("s1_pc%0d", i), {26'd0, instrPC}, i);
      tick();
    end
    check("s1_cnt",  {16'd0, fetchCount}, 32'd8);
    check("s1_addr", {26'd0, imemAddr}, 32'd9);

    // 2: backpressure fills the buffer, then drains without gaps
    do_reset();
    enable = 1'b1; instrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s2_hold_pc%0d", i), {26'd0, instrPC}, 32'd0);
    end
    check("s2_valid", {31'd0, instrValid}, 32'd1);
    check("s2_instr", instr, 32'h1000_0000);
    check("s2_addr",  {26'd0, imemAddr}, 32'd2);
    instrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s2_pc%0d", i), {26'd0, instrPC}, i);
      tick();
    end
    check("s2_cnt", {16'd0, fetchCount}, 32'd4);

    // 3: redirect with a full buffer while popping
    do_reset();
    enable = 1'b1; instrReady = 1'b0;
    tick(); tick(); tick();
    instrReady = 1'b1; redirect = 1'b1; redirectPC = 6'd40;
    tick();
    redirect = 1'b0;
    check("s3_cnt",   {16'd0, fetchCount}, 32'd1);
    check("s3_valid", {31'd0, instrValid}, 32'd0);
    check("s3_instr0", instr, 32'd0);
    check("s3_pc0",   {26'd0, instrPC}, 32'd0);
    check("s3_addr",  {26'd0, imemAddr}, 32'd40);
    tick();
    check("s3_valid40", {31'd0, instrValid}, 32'd1);
    check("s3_pc40",    {26'd0, instrPC}, 32'd40);
    check("s3_instr40", instr, 32'h1000_0028);
    tick();
    check("s3_pc41", {26'd0, instrPC}, 32'd41);

    // 4: PC wrap 62,63,0,1
    redirect = 1'b1; redirectPC = 6'd62;
    tick();
    redirect = 1'b0;
    tick();
    check("s4_pc62", {26'd0, instrPC}, 32'd62);
    tick();
    check("s4_pc63",   {26'd0, instrPC}, 32'd63);
    check("s4_instr63", instr, 32'h1000_003F);
    check("s4_addr0",  {26'd0, imemAddr}, 32'd0);
    tick();
    check("s4_pc0",    {26'd0, instrPC}, 32'd0);
    check("s4_instr0", instr, 32'h1000_0000);
    tick();
    check("s4_pc1", {26'd0, instrPC}, 32'd1);
    check("s4_cnt", {16'd0, fetchCount}, 32'd6);

    // 5: asynchronous reset pulse mid-stream with a full buffer
    instrReady = 1'b0;
    tick(); tick();
    check("s5_full_pc",   {26'd0, instrPC}, 32'd1);
    check("s5_full_addr", {26'd0, imemAddr}, 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("s5_async_valid", {31'd0, instrValid}, 32'd0);
    check("s5_async_addr",  {26'd0, imemAddr}, 32'd0);
    check("s5_async_cnt",   {16'd0, fetchCount}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("s5_first_valid", {31'd0, instrValid}, 32'd1);
    check("s5_first_pc",    {26'd0, instrPC}, 32'd0);
    check("s5_first_instr", instr, 32'h1000_0000);

    // 6: enable low drains the buffer with PC frozen, then resumes
    tick();
    check("s6_full_addr", {26'd0, imemAddr}, 32'd2);
    enable = 1'b0; instrReady = 1'b1;
    check("s6_pc0", {26'd0, instrPC}, 32'd0);
    tick();
    check("s6_valid1", {31'd0, instrValid}, 32'd1);
    check("s6_pc1",    {26'd0, instrPC}, 32'd1);
    check("s6_addr1",  {26'd0, imemAddr}, 32'd2);
    tick();
    check("s6_empty", {31'd0, instrValid}, 32'd0);
    check("s6_addr2", {26'd0, imemAddr}, 32'd2);
    enable = 1'b1;
    tick();
    check("s6_resume_pc",    {26'd0, instrPC}, 32'd2);
    check("s6_resume_instr", instr, 32'h1000_0002);
    check("s6_cnt",          {16'd0, fetchCount}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
